// File: rtl/numarator_modulo_cascadabil.sv
// numarator_modulo_cascadabil: cascadable modulo-MODULUS up/down counter with pause, clear, load and sticky wrap flag
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset (count <= RESET_VAL, depasire <= 0)
//   pauza        1 holds the count; an upstream carry arriving meanwhile is dropped
//   carry_in     step request from the previous stage (tie 1 when standalone)
//   down         0 counts up, 1 counts down
//   clear        synchronous clear to 0 (highest priority)
//   load         synchronous parallel load of load_val, clamped to MODULUS-1
//   load_val     value for load
//   valoare_bin  current count (registered)
//   carry_out    combinational wrap/borrow strobe for the next stage
//   depasire     sticky wrapped-at-least-once flag (registered)
module numarator_modulo_cascadabil #(
  parameter int MODULUS   = 60,
  parameter int WIDTH     = 6,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pauza,
  input  logic             carry_in,
  input  logic             down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] valoare_bin,
  output logic             carry_out,
  output logic             depasire
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RV  = WIDTH'(RESET_VAL);
  if (MODULUS < 2 || (2 ** WIDTH) < MODULUS || RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_params
    $error("numarator_modulo_cascadabil: invalid MODULUS/WIDTH/RESET_VAL");
  end
  logic step, term;
  // Gating step with reset keeps carry_out low for the whole time reset is held.
  assign step      = reset & carry_in & ~pauza & ~clear & ~load;
  assign term      = down ? (valoare_bin == '0) : (valoare_bin == MAX);
  assign carry_out = step & term;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valoare_bin <= RV;
      depasire    <= 1'b0;
    end else if (clear) begin
      valoare_bin <= '0;
      depasire    <= 1'b0;
    end else if (load) begin
      valoare_bin <= (load_val > MAX) ? MAX : load_val;
    end else if (step) begin
      valoare_bin <= term ? (down ? MAX : '0) : (down ? valoare_bin - 1'b1 : valoare_bin + 1'b1);
      depasire    <= depasire | term;
    end
  end
endmodule

// File: tb/tb_numarator_modulo_cascadabil.sv
// tb_numarator_modulo_cascadabil: two cascaded counters checked against an arithmetic model plus directed literals
module tb_numarator_modulo_cascadabil;
  localparam int M = 60;
  logic clk = 1'b0, reset = 1'b0, pauza = 1'b0, cin = 1'b1, down = 1'b0, clear = 1'b0, load = 1'b0;
  logic [5:0] load_val = '0;
  logic [5:0] lo_val, hi_val;
  logic lo_co, hi_co, lo_dep, hi_dep;
  int n_chk = 0, n_fail = 0;
  int m_lo = 0, m_hi = 0;
  bit d_lo = 0, d_hi = 0;
  int hi_pulses, pulse_lo, pulse_hi;

  numarator_modulo_cascadabil u_lo (
    .clk(clk), .reset(reset), .pauza(pauza), .carry_in(cin), .down(down), .clear(clear),
    .load(load), .load_val(load_val), .valoare_bin(lo_val), .carry_out(lo_co), .depasire(lo_dep));
  numarator_modulo_cascadabil u_hi (
    .clk(clk), .reset(reset), .pauza(1'b0), .carry_in(lo_co), .down(down), .clear(clear),
    .load(1'b0), .load_val(6'd0), .valoare_bin(hi_val), .carry_out(hi_co), .depasire(hi_dep));

  always #5 clk = ~clk;

  // Reference model: pure modular arithmetic on integers.
  function automatic bit lo_step();
    return reset && cin && !pauza && !clear && !load;
  endfunction
  function automatic bit exp_lo_co();
    return lo_step() && (down ? (m_lo == 0) : (m_lo == M - 1));
  endfunction
  function automatic bit exp_hi_co();
    return reset && exp_lo_co() && !clear && (down ? (m_hi == 0) : (m_hi == M - 1));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lo = 0; m_hi = 0; d_lo = 0; d_hi = 0;
    end else begin
      automatic bit cl = exp_lo_co(), ch = exp_hi_co(), sl = lo_step(), sh = exp_lo_co() && !clear;
      if (clear) begin
        m_lo = 0; m_hi = 0; d_lo = 0; d_hi = 0;
      end else begin
        if (load) m_lo = (int'(load_val) < M) ? int'(load_val) : M - 1;
        else if (sl) m_lo = down ? (m_lo + M - 1) % M : (m_lo + 1) % M;
        if (sh) m_hi = down ? (m_hi + M - 1) % M : (m_hi + 1) % M;
        d_lo = d_lo | cl;
        d_hi = d_hi | ch;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("lo_val", int'(lo_val), m_lo);
    chk("hi_val", int'(hi_val), m_hi);
    chk("lo_co", int'(lo_co), int'(exp_lo_co()));
    chk("hi_co", int'(hi_co), int'(exp_hi_co()));
    chk("lo_dep", int'(lo_dep), int'(d_lo));
    chk("hi_dep", int'(hi_dep), int'(d_hi));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_val = 6'(v);
    tick();
    load = 1'b0;
  endtask

  initial begin
    #12 reset = 1'b1;
    #1;
    chk("reset_val", int'(lo_val), 0);
    chk("reset_dep", int'(lo_dep), 0);
    chk("reset_co", int'(lo_co), 0);
    // 1: full up cycle
    for (int i = 1; i < M; i++) begin
      tick();
      chk("up_count", int'(lo_val), i);
      if (i < M - 1) chk("up_no_co", int'(lo_co), 0);
    end
    chk("wrap_co", int'(lo_co), 1);
    chk("dep_before_wrap", int'(lo_dep), 0);
    tick();
    chk("wrap_val", int'(lo_val), 0);
    chk("wrap_dep", int'(lo_dep), 1);
    chk("wrap_co_gone", int'(lo_co), 0);
    chk("hi_after_wrap", int'(hi_val), 1);
    // 2: pause
    do_load(17);
    chk("load17", int'(lo_val), 17);
    pauza = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("pause_hold", int'(lo_val), 17);
      chk("pause_co", int'(lo_co), 0);
    end
    pauza = 1'b0;
    tick();
    chk("pause_release", int'(lo_val), 18);
    // 4: down through zero
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_dep", int'(lo_dep), 0);
    do_load(2);
    down = 1'b1;
    tick();
    chk("down_1", int'(lo_val), 1);
    tick();
    chk("down_0", int'(lo_val), 0);
    chk("borrow_co", int'(lo_co), 1);
    tick();
    chk("down_59", int'(lo_val), 59);
    chk("borrow_dep", int'(lo_dep), 1);
    down = 1'b0;
    // 5: clear beats load, load clamps
    clear = 1'b1; load = 1'b1; load_val = 6'd63;
    #1 chk("clr_load_co", int'(lo_co), 0);
    tick();
    chk("clear_wins", int'(lo_val), 0);
    clear = 1'b0;
    tick();
    chk("load_clamp", int'(lo_val), 59);
    chk("load_no_co", int'(lo_co), 0);
    load = 1'b0;
    // 6: asynchronous reset mid-cycle
    do_load(42);
    chk("load42", int'(lo_val), 42);
    #2 reset = 1'b0;
    #1;
    chk("async_val", int'(lo_val), 0);
    chk("async_dep", int'(lo_dep), 0);
    chk("async_co", int'(lo_co), 0);
    tick();
    chk("reset_hold", int'(lo_val), 0);
    reset = 1'b1;
    tick();
    chk("resume_1", int'(lo_val), 1);
    tick();
    chk("resume_2", int'(lo_val), 2);
    // 3: cascade 3600 clocks from 00:00
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("casc_start_lo", int'(lo_val), 0);
    chk("casc_start_hi", int'(hi_val), 0);
    hi_pulses = 0; pulse_lo = -1; pulse_hi = -1;
    for (int i = 0; i < 3600; i++) begin
      if (hi_co) begin
        hi_pulses++;
        pulse_lo = int'(lo_val);
        pulse_hi = int'(hi_val);
      end
      tick();
    end
    chk("casc_pulses", hi_pulses, 1);
    chk("casc_pulse_lo", pulse_lo, 59);
    chk("casc_pulse_hi", pulse_hi, 59);
    chk("casc_end_lo", int'(lo_val), 0);
    chk("casc_end_hi", int'(hi_val), 0);
    chk("casc_hi_dep", int'(hi_dep), 1);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
